// File: rtl/message_stitcher_pkg.sv
// Header layout and state encoding shared by every debug-message producer
// and by the receive-side stitcher.
package message_stitcher_pkg;

    localparam int HDR_RSVD_BIT = 31;
    localparam int HDR_LEN_LSB  = 21;
    localparam int HDR_LEN_W    = 10;
    localparam int HDR_FMT_LSB  = 17;
    localparam int HDR_FMT_W    = 4;
    localparam int HDR_MOD_LSB  = 7;
    localparam int HDR_MOD_W    = 10;
    localparam int HDR_ERR_LSB  = 0;
    localparam int HDR_ERR_W    = 7;

    localparam logic [HDR_FMT_W-1:0] FORMAT_RAW = '0;

    typedef struct packed {
        logic                 rsvd;
        logic [HDR_LEN_W-1:0] length;
        logic [HDR_FMT_W-1:0] format;
        logic [HDR_MOD_W-1:0] mod_key;
        logic [HDR_ERR_W-1:0] err_key;
    } hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

endpackage

// File: rtl/message_stitcher.sv
// Reassembles header+payload word streams into one parallel message bus.
// Latency: out_nd one cycle after the last word (or header when length is 0).
// No backpressure: every in_nd word is consumed; bad or stalled messages are dropped.
module message_stitcher
    import message_stitcher_pkg::*;
#(
    parameter int WDTH    = 32,
    parameter int MAX_LEN = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WDTH-1:0]         in_data,
    input  logic                    in_nd,
    output logic [WDTH-1:0]         out_header,
    output logic [MAX_LEN*WDTH-1:0] out_payload,
    output logic [9:0]              out_length,
    output logic                    out_nd,
    output logic                    error
);

    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

    state_t                  state, state_nxt;
    logic [9:0]              hdr_len_q;
    logic [WDTH-1:0]         hdr_q;
    logic [MAX_LEN*WDTH-1:0] payload_q, payload_nxt;
    logic [9:0]              idx_q;
    logic [9:0]              rem_q;
    logic [GAP_W-1:0]        gap_q;

    logic                 in_rsvd;
    logic [HDR_LEN_W-1:0] in_len;
    logic [HDR_FMT_W-1:0] in_fmt;

    logic complete, set_err, store_word, rem_dec, gap_clr, gap_inc;

    assign in_rsvd = in_data[HDR_RSVD_BIT];
    assign in_len  = in_data[HDR_LEN_LSB +: HDR_LEN_W];
    assign in_fmt  = in_data[HDR_FMT_LSB +: HDR_FMT_W];

    // Current payload with the incoming word merged at the write index.
    always_comb begin
        payload_nxt = payload_q;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (idx_q == 10'(k)) payload_nxt[k*WDTH +: WDTH] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        complete   = 1'b0;
        set_err    = 1'b0;
        store_word = 1'b0;
        rem_dec    = 1'b0;
        gap_clr    = 1'b0;
        gap_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_nd) begin
                    if (in_rsvd) begin
                        set_err = 1'b1;
                    end else if (in_fmt != FORMAT_RAW || in_len > 10'(MAX_LEN)) begin
                        set_err = 1'b1;
                        if (in_len != '0) begin
                            state_nxt = ST_DISCARD;
                            gap_clr   = 1'b1;
                        end
                    end else if (in_len == '0) begin
                        complete = 1'b1;
                    end else begin
                        state_nxt = ST_COLLECT;
                        gap_clr   = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (in_nd) begin
                    store_word = 1'b1;
                    gap_clr    = 1'b1;
                    if (idx_q + 10'd1 == hdr_len_q) begin
                        complete  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (gap_q == GAP_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (in_nd) begin
                    rem_dec = 1'b1;
                    gap_clr = 1'b1;
                    if (rem_q == 10'd1) state_nxt = ST_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q       <= '0;
            hdr_len_q   <= '0;
            payload_q   <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            gap_q       <= '0;
            out_header  <= '0;
            out_payload <= '0;
            out_length  <= '0;
            out_nd      <= 1'b0;
            error       <= 1'b0;
        end else begin
            if (state == ST_IDLE && in_nd) begin
                hdr_q     <= in_data;
                hdr_len_q <= in_len;
                payload_q <= '0;
                idx_q     <= '0;
                rem_q     <= in_len;
            end
            if (store_word) begin
                payload_q <= payload_nxt;
                idx_q     <= idx_q + 10'd1;
            end
            if (rem_dec) rem_q <= rem_q - 10'd1;
            if (gap_clr)      gap_q <= '0;
            else if (gap_inc) gap_q <= gap_q + 1'b1;

            out_nd <= complete;
            if (complete) begin
                // A zero-length message completes straight from its header word.
                if (state == ST_IDLE) begin
                    out_header  <= in_data;
                    out_payload <= '0;
                    out_length  <= '0;
                end else begin
                    out_header  <= hdr_q;
                    out_payload <= payload_nxt;
                    out_length  <= hdr_len_q;
                end
            end
            if (set_err) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_message_stitcher.sv
// Directed-vector bench for message_stitcher with default parameters.
module tb_message_stitcher;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_nd = 1'b0;
    logic [31:0]  out_header;
    logic [127:0] out_payload;
    logic [9:0]   out_length;
    logic         out_nd;
    logic         error;

    int n_chk  = 0;
    int n_pass = 0;

    message_stitcher #(.WDTH(32), .MAX_LEN(4), .TIMEOUT(255)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_nd       (in_nd),
        .out_header  (out_header),
        .out_payload (out_payload),
        .out_length  (out_length),
        .out_nd      (out_nd),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Drive one cycle of input; return 1 time unit after the capturing edge.
    task automatic step(input logic nd, input logic [31:0] d);
        in_nd   = nd;
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_nd = 1'b0;
        rst_n = 1'b0;
        step(1'b0, 32'h0);
        rst_n = 1'b1;
        step(1'b0, 32'h0);
    endtask

    int strobes;

    initial begin
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        chk("rst_out_nd", {127'h0, out_nd}, 128'h0);
        chk("rst_header", {96'h0, out_header}, 128'h0);
        chk("rst_payload", out_payload, 128'h0);
        chk("rst_length", {118'h0, out_length}, 128'h0);
        chk("rst_error", {127'h0, error}, 128'h0);
        rst_n = 1'b1;
        step(1'b0, 32'h0);

        // len-2 message
        step(1'b1, 32'h0040_0283);
        chk("t1_hdr_nd", {127'h0, out_nd}, 128'h0);
        step(1'b1, 32'hDEAD_BEEF);
        chk("t1_w0_nd", {127'h0, out_nd}, 128'h0);
        step(1'b1, 32'h1234_5678);
        chk("t1_nd", {127'h0, out_nd}, 128'h1);
        chk("t1_len", {118'h0, out_length}, 128'd2);
        chk("t1_payload", out_payload, {64'h0, 32'h1234_5678, 32'hDEAD_BEEF});
        chk("t1_header", {96'h0, out_header}, {96'h0, 32'h0040_0283});
        chk("t1_error", {127'h0, error}, 128'h0);
        step(1'b0, 32'h0);
        chk("t1_pulse_width", {127'h0, out_nd}, 128'h0);
        chk("t1_hold_len", {118'h0, out_length}, 128'd2);

        // zero-length message
        step(1'b1, 32'h0000_0000);
        chk("t2_nd", {127'h0, out_nd}, 128'h1);
        chk("t2_len", {118'h0, out_length}, 128'd0);
        chk("t2_payload", out_payload, 128'h0);
        chk("t2_error", {127'h0, error}, 128'h0);
        step(1'b0, 32'h0);

        // oversize: length 5 discarded, then a good len-1 message
        strobes = 0;
        step(1'b1, 32'h00A0_0000);
        chk("t3_err_rise", {127'h0, error}, 128'h1);
        for (int i = 0; i < 5; i++) begin
            strobes += int'(out_nd);
            step(1'b1, 32'h5555_0000 + 32'(i));
        end
        strobes += int'(out_nd);
        chk("t3_no_strobe", 128'(strobes), 128'h0);
        step(1'b1, 32'h0020_0000);
        chk("t3_hdr2_nd", {127'h0, out_nd}, 128'h0);
        step(1'b1, 32'hCAFE_F00D);
        chk("t3_nd", {127'h0, out_nd}, 128'h1);
        chk("t3_len", {118'h0, out_length}, 128'd1);
        chk("t3_payload", out_payload, {96'h0, 32'hCAFE_F00D});
        chk("t3_header", {96'h0, out_header}, {96'h0, 32'h0020_0000});
        step(1'b0, 32'h0);

        // non-raw format, len 1
        do_reset();
        step(1'b1, 32'h0022_0000);
        chk("t4_err", {127'h0, error}, 128'h1);
        step(1'b1, 32'h7777_7777);
        chk("t4_no_nd", {127'h0, out_nd}, 128'h0);
        step(1'b1, 32'h0000_0000);
        chk("t4_idle_again", {127'h0, out_nd}, 128'h1);
        step(1'b0, 32'h0);

        // reserved bit set: dropped in IDLE
        do_reset();
        step(1'b1, 32'h8000_0000);
        chk("rsvd_err", {127'h0, error}, 128'h1);
        chk("rsvd_no_nd", {127'h0, out_nd}, 128'h0);
        step(1'b0, 32'h0);

        // timeout inside COLLECT
        do_reset();
        step(1'b1, 32'h0040_0000);
        step(1'b1, 32'h1111_1111);
        for (int i = 0; i < 254; i++) step(1'b0, 32'h0);
        chk("t5_err_before", {127'h0, error}, 128'h0);
        step(1'b0, 32'h0);
        chk("t5_err_after", {127'h0, error}, 128'h1);
        chk("t5_no_nd", {127'h0, out_nd}, 128'h0);
        step(1'b1, 32'h0020_0000);
        step(1'b1, 32'h2222_2222);
        chk("t5_next_nd", {127'h0, out_nd}, 128'h1);
        chk("t5_next_payload", out_payload, {96'h0, 32'h2222_2222});
        chk("t5_next_len", {118'h0, out_length}, 128'd1);

        // word on the last idle cycle before timeout is accepted
        do_reset();
        step(1'b1, 32'h0020_0000);
        for (int i = 0; i < 254; i++) step(1'b0, 32'h0);
        step(1'b1, 32'h3333_3333);
        chk("tb_edge_nd", {127'h0, out_nd}, 128'h1);
        chk("tb_edge_payload", out_payload, {96'h0, 32'h3333_3333});
        chk("tb_edge_err", {127'h0, error}, 128'h0);
        step(1'b0, 32'h0);

        // back-to-back len-1 messages, then reset mid-message
        do_reset();
        step(1'b1, 32'h0020_0000);
        step(1'b1, 32'hAAAA_0001);
        chk("t6_m1_nd", {127'h0, out_nd}, 128'h1);
        chk("t6_m1_payload", out_payload, {96'h0, 32'hAAAA_0001});
        step(1'b1, 32'h0020_0000);
        chk("t6_hdr2_nd", {127'h0, out_nd}, 128'h0);
        step(1'b1, 32'hBBBB_0002);
        chk("t6_m2_nd", {127'h0, out_nd}, 128'h1);
        chk("t6_m2_payload", out_payload, {96'h0, 32'hBBBB_0002});
        step(1'b1, 32'h0040_0000);
        step(1'b1, 32'h0000_0001);
        in_nd = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_nd", {127'h0, out_nd}, 128'h0);
        chk("t6_rst_header", {96'h0, out_header}, 128'h0);
        chk("t6_rst_payload", out_payload, 128'h0);
        chk("t6_rst_len", {118'h0, out_length}, 128'h0);
        chk("t6_rst_err", {127'h0, error}, 128'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0000);
        chk("t6_after_rst_nd", {127'h0, out_nd}, 128'h1);
        chk("t6_after_rst_err", {127'h0, error}, 128'h0);
        step(1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/message_stitcher.md
# message_stitcher

Receive-side counterpart of the debug message path: accepts a stream of WDTH-bit message words (header word followed by payload words) and reassembles each message into one parallel output bus, one strobe per message. It sits at the host/test-harness end of the debug link, downstream of any block that emits messages word-by-word. Malformed, oversize or stalled messages are discarded and flagged.

## Interface
- WDTH, 32, word width; must be ≥ 32; header fields occupy bits [31:0].
- MAX_LEN, 4, maximum payload words per message (excluding header).
- TIMEOUT, 255, max idle cycles between payload words before the message is abandoned; ≥ 1.

- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_data  in  WDTH  message word
- in_nd  in  1  in_data valid this cycle
- out_header  out  WDTH  header word of completed message
- out_payload  out  MAX_LEN*WDTH  payload; word k at bits [(k+1)*WDTH-1 : k*WDTH]
- out_length  out  10  payload word count of completed message
- out_nd  out  1  one-cycle strobe: out_* valid
- error  out  1  sticky; set on any discarded message, cleared only by reset

## Operation
- Header layout: [31] reserved (must be 0), [30:21] length, [20:17] format, [16:7] module key, [6:0] error key.
- States: IDLE, COLLECT, DISCARD.
- IDLE, in_nd: latch header; clear payload register to 0; word index ← 0.
  - reserved bit = 1: drop word, set error, stay IDLE.
  - format ≠ 0 or length > MAX_LEN: set error; length = 0 → stay IDLE, else → DISCARD with remaining = length.
  - length = 0: complete immediately (out_nd next cycle, out_payload = 0).
  - else → COLLECT.
- COLLECT, in_nd: store in_data at word index, increment; on final word complete message, → IDLE.
- DISCARD, in_nd: decrement remaining; at 0 → IDLE. No output.
- Gap counter: cleared on every in_nd and on entry to COLLECT/DISCARD; in COLLECT/DISCARD, reaching TIMEOUT cycles without in_nd sets error and → IDLE, partial message dropped.
- Completion loads out_header, out_payload, out_length; these hold until the next completion.
- No backpressure: every in_nd word is consumed.

## Timing
- Reset (async): state IDLE, all outputs 0, counters 0; a partial message in flight is lost without setting error.
- Latency: out_nd asserts exactly 1 cycle after the in_nd of the last payload word (or of the header when length = 0); pulse width 1 cycle.
- Back-to-back: a header on the cycle immediately after a final word is accepted as a new message; out_nd of the first and header capture of the second coincide without interference.
- Word with in_nd in the same cycle the gap counter would hit TIMEOUT: word accepted, no timeout.
- error rises the cycle after the offending word or timeout cycle.

## Structure
- Shared include/package: header field offsets and widths (reserved, length, format, module key, error key), FORMAT_RAW = 0, state encoding; shared with all message producers.
- Single module; no sub-module needed (payload capture is an indexed register write, not a separate block).

## Test plan
- Header 0x00400283 (len 2, module 5, err 3), then 0xDEADBEEF, 0x12345678 -> out_nd 1 cycle after second word, out_length 2, out_payload[31:0]=0xDEADBEEF, [63:32]=0x12345678, upper words 0, error 0.
- Header 0x00000000 -> out_nd next cycle, out_length 0, out_payload all 0.
- Header 0x00A00000 (len 5 > MAX_LEN 4), five words, then valid len-1 message -> no out_nd for first, error = 1, second message delivered correctly.
- Header 0x00220000 (format 1, len 1), one word -> discarded, error = 1, state back to IDLE.
- Header 0x00400000, one word, then TIMEOUT idle cycles -> no out_nd, error = 1; following len-1 message delivered.
- Two len-1 messages back-to-back with in_nd held high, then rst_n pulsed mid-message -> two out_nd strobes, then all outputs 0 and error 0 after reset.
